// File: rtl/xbar_master_port.sv
// xbar_master_port
// One output lane of the streaming crossbar, instantiated once per master.
// The lane selects the slave streams addressed to MASTER_ID and arbitrates
// among them round-robin. It then stays locked on the winner until that
// packet's last beat. The winner's payload goes to the master, and the
// master's ready goes back to the winner only.
//
// Optional build macro XBAR_OUT_REG_EN:
//   defined   - a 2-entry skid buffer registers {data,last,id} in front of the
//               master outputs. This adds one cycle of latency and keeps full
//               throughput.
//   undefined - the master outputs are a combinational pass-through of the
//               locked slave, with no added latency.
//
// All logic runs on the rising edge of clk. rst is synchronous and active-high.

module xbar_master_port #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 5,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
    parameter int MASTER_ID    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_valid_o,
    output logic                                 m_last_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    input  logic                                 m_ready_i,
    output logic                                 busy_o
);

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);
    localparam logic [T_DEST_WIDTH-1:0] MY_DEST  = T_DEST_WIDTH'(MASTER_ID);

    logic [0:0]              state_q, state_d;
    logic [T_ID___WIDTH-1:0] ptr_q,   ptr_d;
    logic [T_ID___WIDTH-1:0] gnt_q,   gnt_d;

    logic [S_DATA_COUNT-1:0] req;
    logic [T_DATA_WIDTH-1:0] s_data_arr [S_DATA_COUNT];

    logic                    found;
    logic [T_ID___WIDTH-1:0] winner;

    logic                    locked;
    logic                    sel_valid;
    logic                    sel_last;
    logic [T_DATA_WIDTH-1:0] sel_data;

    // Ready presented to the locked slave, and a beat taken from it.
    logic                    src_ready;
    logic                    beat_in;

    // Unpack the slave payloads and decode which streams target this master.
    always_comb begin
        // NOTE: every signal written here gets a default first. A path that skips an assignment would otherwise infer a latch.
        req = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            s_data_arr[i] = s_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
            req[i]        = s_valid_i[i] &&
                            (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == MY_DEST);
        end
    end

    // Round-robin search. The first set request at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            if (!found && req[T_ID___WIDTH'((int'(ptr_q) + k) % S_DATA_COUNT)]) begin
                found  = 1'b1;
                winner = T_ID___WIDTH'((int'(ptr_q) + k) % S_DATA_COUNT);
            end
        end
    end

    assign locked    = (state_q == ST_LOCK);
    assign sel_valid = s_valid_i[gnt_q];
    assign sel_last  = s_last_i[gnt_q];
    assign sel_data  = s_data_arr[gnt_q];
    assign beat_in   = locked && sel_valid && src_ready;
    assign busy_o    = locked;

    // Route the ready only to the locked slave. All other slaves see 0.
    always_comb begin
        s_ready_o = '0;
        if (locked) begin
            s_ready_o[gnt_q] = src_ready;
        end
    end

    // Arbitration and lock control.
    // Destination changes are ignored while locked because req is only consulted in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d   = winner;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (beat_in && sel_last) begin
                    ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + T_ID___WIDTH'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, pointer and grant registers.
    // A reset mid-packet drops the lock, so the packet's remainder re-arbitrates.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef XBAR_OUT_REG_EN

    // Two-entry skid buffer between the mux and the master outputs.
    logic [T_DATA_WIDTH-1:0] buf_data_q [2];
    logic                    buf_last_q [2];
    logic [T_ID___WIDTH-1:0] buf_id_q   [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic                    buf_rd;

    // The slave may push whenever a slot is free. Ready does not depend on m_ready_i.
    assign src_ready = (count_q != 2'd2);
    assign buf_rd    = (count_q != 2'd0) && m_ready_i;

    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = buf_data_q[rd_ptr_q];
    assign m_last_o  = buf_last_q[rd_ptr_q];
    assign m_id_o    = buf_id_q[rd_ptr_q];

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is cleared on reset as well as the occupancy, so the master outputs show zeros after reset.
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
                buf_id_q[i]   <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (beat_in) begin
                buf_data_q[wr_ptr_q] <= sel_data;
                buf_last_q[wr_ptr_q] <= sel_last;
                buf_id_q[wr_ptr_q]   <= gnt_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (buf_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({beat_in, buf_rd})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`else

    // Pass-through: the locked slave sees the master's ready directly.
    assign src_ready = m_ready_i;

    // Drive the master from the locked slave. Outputs are zero while idle.
    always_comb begin
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        m_data_o  = '0;
        m_id_o    = '0;
        if (locked) begin
            m_valid_o = sel_valid;
            m_last_o  = sel_last;
            m_data_o  = sel_data;
            m_id_o    = gnt_q;
        end
    end

`endif

endmodule

// File: tb/tb_xbar_master_port.sv
// tb_xbar_master_port
// Scoreboard bench for xbar_master_port with MASTER_ID=1. It works both with
// and without XBAR_OUT_REG_EN.
// Each slave plays packets from its own beat queue. The beats the master is
// expected to see are queued in predicted grant order when the stimulus is
// created. They are popped and compared as the master accepts beats.

module tb_xbar_master_port;

    localparam int DW  = 8;
    localparam int SN  = 5;
    localparam int IDW = 3;
    localparam int DSW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [DSW-1:0] dest;
    } sbeat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [SN*DW-1:0]   s_data_i;
    logic [SN-1:0]      s_valid_i;
    logic [SN-1:0]      s_last_i;
    logic [SN*DSW-1:0]  s_dest_i;
    logic [SN-1:0]      s_ready_o;
    logic [DW-1:0]      m_data_o;
    logic               m_valid_o;
    logic               m_last_o;
    logic [IDW-1:0]     m_id_o;
    logic               m_ready_i;
    logic               busy_o;

    xbar_master_port #(
        .T_DATA_WIDTH(DW),
        .S_DATA_COUNT(SN),
        .M_DATA_COUNT(3),
        .MASTER_ID   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .s_dest_i  (s_dest_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_id_o    (m_id_o),
        .m_ready_i (m_ready_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    sbeat_t        slv_q [SN][$];
    beat_t         exp_q [$];
    logic [SN-1:0] hs;
    logic [SN-1:0] forbid_mask;
    logic          rst_ctl;
    logic          mready_ctl;
    int            n_vec;
    int            n_err;
    int            cyc;
    int            beats_seen;
    int            last_beat_cyc;
    bit            last_was_last;
    bit            gap_chk;
    bit            s1_chk;
    bit            prev_stall;
    beat_t         prev_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk_beat(input int s, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.id   = IDW'(s);
        b.data = d;
        b.last = l;
        return b;
    endfunction

    task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l,
                             input logic [DSW-1:0] dst, input bit expect_out);
        sbeat_t sb;
        sb.data = d;
        sb.last = l;
        sb.dest = dst;
        slv_q[s].push_back(sb);
        if (expect_out) exp_q.push_back(mk_beat(s, d, l));
    endtask

    task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base,
                            input logic [DSW-1:0] dst, input bit expect_out);
        for (int k = 0; k < n; k++)
            push_beat(s, DW'(int'(base) + k), (k == n - 1), dst, expect_out);
    endtask

    // Advance one cycle: apply the slave pops and drive inputs after the
    // rising edge, then sample and check at the falling edge.
    task automatic step();
        sbeat_t sb;
        beat_t  out_b;
        beat_t  e;
        @(posedge clk);
        #1;
        for (int i = 0; i < SN; i++)
            if (hs[i] && slv_q[i].size() > 0) sb = slv_q[i].pop_front();
        rst       = rst_ctl;
        m_ready_i = mready_ctl;
        for (int i = 0; i < SN; i++) begin
            if (slv_q[i].size() > 0) begin
                sb = slv_q[i][0];
                s_valid_i[i]             = 1'b1;
                s_data_i[i*DW +: DW]     = sb.data;
                s_last_i[i]              = sb.last;
                s_dest_i[i*DSW +: DSW]   = sb.dest;
            end else begin
                s_valid_i[i]             = 1'b0;
                s_data_i[i*DW +: DW]     = '0;
                s_last_i[i]              = 1'b0;
                s_dest_i[i*DSW +: DSW]   = '0;
            end
        end
        @(negedge clk);
        cyc++;
        check("ready_onehot", 32'($onehot0(s_ready_o)), 32'd1);
        check("ready_to_idle_slave", 32'(s_ready_o & forbid_mask), 32'd0);
        if (s1_chk && busy_o) check("s1_ready", 32'(s_ready_o), 32'(5'b00100));
        out_b = {m_id_o, m_data_o, m_last_o};
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid_o), 32'd1);
            check("stall_hold", 32'(out_b), 32'(prev_out));
        end
        prev_stall = m_valid_o && !m_ready_i && !rst;
        prev_out   = out_b;
        if (m_valid_o && m_ready_i) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'(out_b), 32'(e));
                if (gap_chk && last_beat_cyc >= 0)
                    check("beat_gap", cyc - last_beat_cyc, last_was_last ? 2 : 1);
                last_beat_cyc = cyc;
                last_was_last = e.last;
            end
        end
        for (int i = 0; i < SN; i++) hs[i] = s_valid_i[i] && s_ready_o[i];
    endtask

    task automatic do_reset();
        for (int i = 0; i < SN; i++) slv_q[i].delete();
        exp_q.delete();
        rst_ctl    = 1'b1;
        mready_ctl = 1'b1;
        step();
        rst_ctl    = 1'b0;
        step();
        prev_stall    = 1'b0;
        last_beat_cyc = -1;
        gap_chk       = 1'b0;
        s1_chk        = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
        check({tag, "_m_last"},  32'(m_last_o),  32'd0);
        check({tag, "_m_data"},  32'(m_data_o),  32'd0);
        check({tag, "_m_id"},    32'(m_id_o),    32'd0);
        check({tag, "_busy"},    32'(busy_o),    32'd0);
        check({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
    endtask

    // Run until every expected beat has been seen, or the budget runs out.
    task automatic drain(input string tag, input int budget, input bit toggle_ready);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle_ready) mready_ctl = (n % 2 == 0);
            step();
            n++;
        end
        mready_ctl = 1'b1;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        step();
        check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int     n;
        int     start;
        sbeat_t sb;

        rst = 1'b1;  m_ready_i = 1'b0;
        s_data_i = '0; s_valid_i = '0; s_last_i = '0; s_dest_i = '0;
        hs = '0; forbid_mask = '0; rst_ctl = 1'b1; mready_ctl = 1'b1;
        n_vec = 0; n_err = 0; cyc = 0; beats_seen = 0; last_beat_cyc = -1;
        last_was_last = 1'b0; gap_chk = 1'b0; s1_chk = 1'b0; prev_stall = 1'b0;
        prev_out = '0;

        // Reset state.
        do_reset();
        check_reset_outputs("reset");

        // 1: single source, slave 2.
        forbid_mask = 5'b11011;
        s1_chk      = 1'b1;
        push_beat(2, 8'hA1, 1'b0, 2'd1, 1'b1);
        push_beat(2, 8'hA2, 1'b0, 2'd1, 1'b1);
        push_beat(2, 8'hA3, 1'b1, 2'd1, 1'b1);
        drain("s1", 30, 1'b0);

        // 2: round-robin among slaves 0, 3, 4. Expected grant order is 0, 3, 4, 0.
        do_reset();
        forbid_mask = 5'b00110;
        gap_chk     = 1'b1;
        push_pkt(0, 2, 8'h00, 2'd1, 1'b0);
        push_pkt(0, 2, 8'h08, 2'd1, 1'b0);
        push_pkt(3, 2, 8'h30, 2'd1, 1'b0);
        push_pkt(4, 2, 8'h40, 2'd1, 1'b0);
        exp_q.push_back(mk_beat(0, 8'h00, 1'b0));
        exp_q.push_back(mk_beat(0, 8'h01, 1'b1));
        exp_q.push_back(mk_beat(3, 8'h30, 1'b0));
        exp_q.push_back(mk_beat(3, 8'h31, 1'b1));
        exp_q.push_back(mk_beat(4, 8'h40, 1'b0));
        exp_q.push_back(mk_beat(4, 8'h41, 1'b1));
        exp_q.push_back(mk_beat(0, 8'h08, 1'b0));
        exp_q.push_back(mk_beat(0, 8'h09, 1'b1));
        drain("s2", 60, 1'b0);

        // 3: destination filter. Slave 1 targets master 2 and slave 4 targets master 1.
        do_reset();
        forbid_mask = 5'b01111;
        push_pkt(1, 2, 8'h10, 2'd2, 1'b0);
        push_pkt(4, 2, 8'h4A, 2'd1, 1'b1);
        drain("s3", 30, 1'b0);
        check("s3_slave1_untouched", 32'(slv_q[1].size()), 32'd2);

        // 4: backpressure on a 4-beat packet from slave 0.
        do_reset();
        forbid_mask = 5'b11110;
        push_pkt(0, 4, 8'hC0, 2'd1, 1'b1);
        drain("s4", 60, 1'b1);

        // 5: slave 4 holds the lock through a dest change. ptr then wraps to 0.
        do_reset();
        forbid_mask = 5'b00110;
        push_beat(4, 8'h51, 1'b0, 2'd1, 1'b1);
        push_beat(4, 8'h52, 1'b0, 2'd0, 1'b1);
        push_beat(4, 8'h53, 1'b1, 2'd0, 1'b1);
        n = 0;
        while (!busy_o && n < 20) begin step(); n++; end
        check("s5_locked", 32'(busy_o), 32'd1);
        push_pkt(0, 2, 8'h60, 2'd1, 1'b1);
        push_pkt(3, 1, 8'h70, 2'd1, 1'b1);
        push_pkt(4, 1, 8'h80, 2'd1, 1'b1);
        drain("s5", 60, 1'b0);

        // 6: reset in the middle of a 5-beat packet. ptr is nonzero beforehand.
        do_reset();
        forbid_mask = 5'b00011;
        push_pkt(3, 1, 8'h3F, 2'd1, 1'b1);
        drain("s6_pre", 30, 1'b0);
        push_pkt(2, 5, 8'h21, 2'd1, 1'b1);
        start = beats_seen;
        n     = 0;
        while ((beats_seen - start) < 2 && n < 40) begin step(); n++; end
        check("s6_two_beats", beats_seen - start, 2);
        push_pkt(4, 1, 8'h4E, 2'd1, 1'b0);
        rst_ctl    = 1'b1;
        mready_ctl = 1'b0;
        step();
        rst_ctl    = 1'b0;
        mready_ctl = 1'b1;
        step();
        check_reset_outputs("s6_reset");
        // Beats already handed to the DUT are dropped by the reset. What is
        // still queued at the slaves must arrive with slave 2 first, since
        // ptr restarts at 0.
        exp_q.delete();
        for (int k = 0; k < slv_q[2].size(); k++) begin
            sb = slv_q[2][k];
            exp_q.push_back(mk_beat(2, sb.data, sb.last));
        end
        for (int k = 0; k < slv_q[4].size(); k++) begin
            sb = slv_q[4][k];
            exp_q.push_back(mk_beat(4, sb.data, sb.last));
        end
        drain("s6", 40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
